chunk_adder_seq: RTL and testbench



---
 rtl/chunk_adder_seq.sv | 117 +++++++++++
 tb/tb_chunk_adder_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_adder_seq.sv
// chunk_adder_seq: multi-cycle adder/subtractor that processes CHUNK bits
// per clock through a registered carry, with valid/ready on both sides.
module chunk_adder_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             v,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("chunk_adder_seq: illegal WIDTH/CHUNK combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      lo;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             last;
   logic             accept;

   assign accept    = in_valid && (state == IDLE);
   assign lo        = 32'(cnt_q) * 32'(CHUNK);
   assign a_chunk   = a_q[lo +: CHUNK];
   assign b_chunk   = b_q[lo +: CHUNK];
   assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
   assign last      = (cnt_q == CNT_W'(NCHUNK - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/status outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture; subtraction is folded in as a + ~b + 1
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= a;
         b_q <= sub ? ~b : b;
      end
   end

   // Chunk-serial add: one slice of s per RUN edge, flags on the final slice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s       <= '0;
         c       <= 1'b0;
         v       <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         carry_q <= sub ? 1'b1 : cin;
         cnt_q   <= '0;
      end else if (state == RUN) begin
         s[lo +: CHUNK] <= chunk_sum[CHUNK-1:0];
         carry_q        <= chunk_sum[CHUNK];
         cnt_q          <= last ? '0 : cnt_q + 1'b1;
         if (last) begin
            c <= chunk_sum[CHUNK];
            // carry into the MSB is recovered from the MSB's own sum bit
            v <= chunk_sum[CHUNK] ^
                 (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1]);
         end
      end
   end

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Bench for chunk_adder_seq: three instances (CHUNK = 4, 1, 16) with a
// per-instance expected-result queue drained by a monitor on output handshakes.
module tb_chunk_adder_seq;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        v;
   } res_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      iv, ir, ov, bsy, ordy, ordy_man, ordy_rnd;
   logic [15:0]     a, b;
   logic            cin, sub;
   logic [2:0][15:0] so;
   logic [2:0]      co, vo;
   bit              rand_mode;

   int   errors = 0;
   int   checks = 0;
   int   nch [3] = '{4, 16, 1};
   res_t sbq [3][$];

   always #5 clk = ~clk;

   assign ordy = rand_mode ? ordy_rnd : ordy_man;

   chunk_adder_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]),
      .s(so[0]), .c(co[0]), .v(vo[0]), .busy(bsy[0]));

   chunk_adder_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]),
      .s(so[1]), .c(co[1]), .v(vo[1]), .busy(bsy[1]));

   chunk_adder_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]),
      .s(so[2]), .c(co[2]), .v(vo[2]), .busy(bsy[2]));

   // Reference: plain integer arithmetic on the whole operands
   function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, input logic sb);
      res_t        e;
      int          sx, sy, r;
      logic [16:0] u;
      sx = $signed(x);
      sy = $signed(y);
      if (sb) begin
         e.s = x - y;
         e.c = (x >= y);
         r   = sx - sy;
      end else begin
         u   = {1'b0, x} + {1'b0, y} + 17'(ci);
         e.s = u[15:0];
         e.c = u[16];
         r   = sx + sy + int'(ci);
      end
      e.v = (r > 32767) || (r < -32768);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Random backpressure source
   always @(posedge clk) begin
      #1;
      ordy_rnd = 3'($urandom);
   end

   // Monitor: compare every accepted result against the head of its queue
   always @(negedge clk) begin
      res_t e;
      for (int d = 0; d < 3; d++) begin
         if (rst_n && ov[d] && ordy[d]) begin
            if (sbq[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result dut%0d: got s=0x%0h with no pending op", d, so[d]);
            end else begin
               e = sbq[d].pop_front();
               chk($sformatf("s dut%0d", d), 32'(so[d]), 32'(e.s));
               chk($sformatf("c dut%0d", d), 32'(co[d]), 32'(e.c));
               chk($sformatf("v dut%0d", d), 32'(vo[d]), 32'(e.v));
            end
         end
      end
   end

   // Present one operation to instance d; optionally check latency timing
   task automatic issue(input int d, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic xs, input bit push, input bit lat);
      int n;
      bit got;
      n   = 0;
      got = 0;
      while (!got && n <= 300) begin
         @(negedge clk);
         if (ir[d]) got = 1;
         else n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout dut%0d: in_ready low for %0d cycles, required high", d, n);
         return;
      end
      a = xa; b = xb; cin = xc; sub = xs;
      iv[d] = 1'b1;
      @(posedge clk);
      if (push) sbq[d].push_back(model(xa, xb, xc, xs));
      #1;
      iv[d] = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (lat) begin
         for (int k = 1; k <= nch[d]; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("out_valid edge%0d dut%0d", k, d), 32'(ov[d]), 32'(k == nch[d]));
            chk($sformatf("in_ready edge%0d dut%0d", k, d), 32'(ir[d]), 32'd0);
         end
         if (ordy[d]) begin
            @(posedge clk);
            #1;
            chk($sformatf("out_valid drop dut%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("in_ready back dut%0d", d), 32'(ir[d]), 32'd1);
         end
      end
   endtask

   initial begin
      int waited;
      rst_n = 1'b0; iv = '0; ordy_man = 3'b111; rand_mode = 0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #3;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst s dut%0d", d), 32'(so[d]), 32'd0);
         chk($sformatf("rst cv dut%0d", d), 32'({co[d], vo[d]}), 32'd0);
         chk($sformatf("rst out_valid dut%0d", d), 32'(ov[d]), 32'd0);
         chk($sformatf("rst busy dut%0d", d), 32'(bsy[d]), 32'd0);
         chk($sformatf("rst in_ready dut%0d", d), 32'(ir[d]), 32'd1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases with full latency checking
      issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1);
      issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1);
      issue(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 1);
      issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1);
      issue(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1, 1);
      issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1, 1);
      issue(0, 16'h0007, 16'h0005, 1'b0, 1'b1, 1, 1);

      // Backpressure: result held while new operands are offered
      ordy_man[0] = 1'b0;
      issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1;
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
         @(posedge clk);
         #1;
         chk("hold out_valid", 32'(ov[0]), 32'd1);
         chk("hold in_ready", 32'(ir[0]), 32'd0);
         chk("hold s", 32'(so[0]), 32'h5555);
         chk("hold cv", 32'({co[0], vo[0]}), 32'd0);
      end
      iv[0] = 1'b0;
      ordy_man[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("release out_valid", 32'(ov[0]), 32'd0);
      chk("release in_ready", 32'(ir[0]), 32'd1);
      issue(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1, 1);
      issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1, 1);

      // Asynchronous reset in the middle of RUN
      issue(0, 16'hABCD, 16'h1357, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun rst s", 32'(so[0]), 32'd0);
      chk("midrun rst cv", 32'({co[0], vo[0]}), 32'd0);
      chk("midrun rst out_valid", 32'(ov[0]), 32'd0);
      chk("midrun rst busy", 32'(bsy[0]), 32'd0);
      chk("midrun rst in_ready", 32'(ir[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1, 1);

      // Randomised traffic with random backpressure
      rand_mode = 1;
      for (int k = 0; k < 40; k++)
         issue(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 0);

      // Extreme chunk sizes
      rand_mode = 0;
      issue(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1);
      issue(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1);
      issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1);
      issue(2, 16'h0005, 16'h0007, 1'b1, 1'b1, 1, 1);
      rand_mode = 1;
      for (int k = 0; k < 6; k++) begin
         issue(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 0);
         issue(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 0);
      end

      // Drain outstanding results
      rand_mode = 0;
      waited = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && waited < 100) begin
         @(posedge clk);
         waited++;
      end
      repeat (2) @(posedge clk);
      for (int d = 0; d < 3; d++)
         chk($sformatf("pending results dut%0d", d), 32'(sbq[d].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
